// File: rtl/ysyx_25060170_ifu_fetch.sv
// ysyx_25060170_ifu_fetch: registered-PC fetch unit with a valid/ready imem request channel and a valid/ready IDU output.
module ysyx_25060170_ifu_fetch #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic            ifu_inst_valid,
    output logic [XLEN-1:0] ifu_inst,
    output logic [XLEN-1:0] ifu_pc,
    input  logic            idu_ready,
    input  logic            jump_valid,
    input  logic [XLEN-1:0] jump_Addr
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] inst_q, inst_d;
    logic            drop_q, drop_d;
    logic [XLEN-1:0] jump_tgt;

    assign jump_tgt = jump_Addr & ~{{(XLEN-2){1'b0}}, 2'b11};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            inst_q  <= '0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
            drop_q  <= drop_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = REQ;
            REQ:     state_d = imem_req_ready ? WAIT : REQ;
            WAIT:    state_d = !imem_rsp_valid ? WAIT : (drop_q || jump_valid) ? REQ : HOLD;
            HOLD:    state_d = (jump_valid || idu_ready) ? REQ : HOLD;
            default: state_d = IDLE;
        endcase
    end

    // A redirect always wins over the sequential pc+4 step.
    always_comb begin
        pc_d   = jump_valid ? jump_tgt : (state_q == HOLD && idu_ready) ? pc_q + XLEN'(4) : pc_q;
        inst_d = (state_q == WAIT && imem_rsp_valid && !drop_q && !jump_valid) ? imem_rsp_data : inst_q;
        drop_d = drop_q;
        if (state_q == REQ && imem_req_ready && jump_valid)
            drop_d = 1'b1;
        if (state_q == WAIT)
            drop_d = imem_rsp_valid ? 1'b0 : (drop_q | jump_valid);
    end

    always_comb begin
        imem_req_valid = (state_q == REQ);
        imem_req_addr  = pc_q;
        ifu_inst_valid = (state_q == HOLD);
        ifu_inst       = inst_q;
        ifu_pc         = pc_q;
    end
endmodule

// File: tb/tb_ysyx_25060170_ifu_fetch.sv
// tb_ysyx_25060170_ifu_fetch: directed plan scenarios plus randomized traffic checked against a transaction-level fetch model.
module tb_ysyx_25060170_ifu_fetch;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req_valid, imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = 32'h0;
    logic        ifu_inst_valid;
    logic [31:0] ifu_inst, ifu_pc;
    logic        idu_ready = 1'b0;
    logic        jump_valid = 1'b0;
    logic [31:0] jump_Addr = 32'h0;

    ysyx_25060170_ifu_fetch #(.XLEN(32), .RESET_PC(32'h8000_0000)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .ifu_inst_valid(ifu_inst_valid), .ifu_inst(ifu_inst), .ifu_pc(ifu_pc),
        .idu_ready(idu_ready), .jump_valid(jump_valid), .jump_Addr(jump_Addr)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int q_due[$];

    // Model: started after first clock, one fetch in flight (possibly stale), or one instruction held.
    bit          m_started, m_pending, m_stale, m_have;
    logic [31:0] m_pc, m_buf;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_started = 0; m_pending = 0; m_stale = 0; m_have = 0;
        m_pc = 32'h8000_0000; m_buf = 32'h0;
        q_due.delete();
    endtask

    task automatic check_model();
        bit rv;
        rv = m_started && !m_pending && !m_have;
        chk("req_valid", 32'(imem_req_valid), 32'(rv));
        if (rv) chk("req_addr", imem_req_addr, m_pc);
        chk("inst_valid", 32'(ifu_inst_valid), 32'(m_have));
        if (m_have) begin
            chk("inst", ifu_inst, m_buf);
            chk("pc", ifu_pc, m_pc);
        end
    endtask

    // Called at a negedge: drive one cycle of inputs, advance the model, then check after the edge.
    task automatic step(input bit rdy, input bit rv, input logic [31:0] rd,
                        input bit jv, input logic [31:0] ja, input bit ir);
        bit accept;
        imem_req_ready = rdy; imem_rsp_valid = rv; imem_rsp_data = rd;
        jump_valid = jv; jump_Addr = ja; idu_ready = ir;
        accept = m_started && m_have && ir;
        if (!m_started)
            m_started = 1;
        else if (!m_pending && !m_have) begin
            if (rdy) begin m_pending = 1; m_stale = jv; end
        end else if (m_pending) begin
            if (rv) begin
                m_pending = 0;
                if (!m_stale && !jv) begin m_have = 1; m_buf = rd; end
                m_stale = 0;
            end else if (jv) m_stale = 1;
        end else if (jv || ir) m_have = 0;
        if (jv) m_pc = ja & 32'hFFFF_FFFC;
        else if (accept) m_pc = m_pc + 32'd4;
        @(negedge clk);
        cyc++;
        check_model();
    endtask

    initial begin
        bit rdy, rv, jv, ir, hs;
        logic [31:0] ja;
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_req_valid", 32'(imem_req_valid), 32'h0);
        chk("rst_inst_valid", 32'(ifu_inst_valid), 32'h0);
        chk("rst_inst", ifu_inst, 32'h0);
        chk("rst_pc", ifu_pc, 32'h8000_0000);
        rst_n = 1'b1;
        check_model();

        // first fetch, 1-cycle memory
        step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        chk("t1_req_valid", 32'(imem_req_valid), 32'h1);
        chk("t1_addr", imem_req_addr, 32'h8000_0000);
        step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        chk("t1_wait_novalid", 32'(imem_req_valid), 32'h0);
        step(1'b0, 1'b1, 32'h0000_0413, 1'b0, 32'h0, 1'b0);
        chk("t1_inst_valid", 32'(ifu_inst_valid), 32'h1);
        chk("t1_inst", ifu_inst, 32'h0000_0413);
        chk("t1_pc", ifu_pc, 32'h8000_0000);
        step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        chk("t1_next_addr", imem_req_addr, 32'h8000_0004);

        // memory back-pressure
        repeat (4) begin
            step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
            chk("t2_valid_held", 32'(imem_req_valid), 32'h1);
            chk("t2_addr_held", imem_req_addr, 32'h8000_0004);
        end
        step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b1, 32'h0000_0011, 1'b0, 32'h0, 1'b0);

        // IDU back-pressure
        repeat (5) begin
            step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
            chk("t3_inst_held", ifu_inst, 32'h0000_0011);
            chk("t3_pc_held", ifu_pc, 32'h8000_0004);
            chk("t3_no_req", 32'(imem_req_valid), 32'h0);
        end
        step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        chk("t3_next_addr", imem_req_addr, 32'h8000_0008);

        // redirect while waiting: late response must be dropped
        step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b1, 32'h8000_0100, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 32'h0, 1'b1);
        chk("t4_dropped", 32'(ifu_inst_valid), 32'h0);
        chk("t4_req_valid", 32'(imem_req_valid), 32'h1);
        chk("t4_addr", imem_req_addr, 32'h8000_0100);

        // redirect beats pc+4 in HOLD
        step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b1, 32'h0000_0022, 1'b0, 32'h0, 1'b0);
        chk("t5_pc", ifu_pc, 32'h8000_0100);
        step(1'b0, 1'b0, 32'h0, 1'b1, 32'h8000_0203, 1'b1);
        chk("t5_addr", imem_req_addr, 32'h8000_0200);

        // redirect in REQ without handshake, then pc wrap
        step(1'b0, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC, 1'b0);
        chk("t6_redir_addr", imem_req_addr, 32'hFFFF_FFFC);
        step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b1, 32'h0000_0033, 1'b0, 32'h0, 1'b0);
        chk("t6_pc", ifu_pc, 32'hFFFF_FFFC);
        step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        chk("t6_wrap_addr", imem_req_addr, 32'h0000_0000);

        // asynchronous reset in WAIT
        step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("t7_req_valid", 32'(imem_req_valid), 32'h0);
        chk("t7_inst_valid", 32'(ifu_inst_valid), 32'h0);
        chk("t7_inst", ifu_inst, 32'h0);
        chk("t7_pc", ifu_pc, 32'h8000_0000);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        check_model();
        step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        chk("t7_restart_addr", imem_req_addr, 32'h8000_0000);

        // randomized traffic with variable memory latency and stray responses
        for (int i = 0; i < 3000; i++) begin
            rdy = $urandom_range(0, 9) < 6;
            ir  = $urandom_range(0, 1) == 1;
            jv  = $urandom_range(0, 9) == 0;
            ja  = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFE : $urandom;
            rv  = 1'b0;
            if (q_due.size() > 0 && cyc >= q_due[0]) begin
                rv = 1'b1;
                void'(q_due.pop_front());
            end else if (q_due.size() == 0 && !m_pending && $urandom_range(0, 7) == 0)
                rv = 1'b1;
            hs = m_started && !m_pending && !m_have && rdy;
            step(rdy, rv, $urandom, jv, ja, ir);
            if (hs) q_due.push_back(cyc + int'($urandom_range(0, 3)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
